// File: rtl/mem_pkg.sv
// Shared definitions for the clearable RAM family: sequencer state encoding and a
// constant-foldable ceil(log2) for tools without a usable $clog2.
package mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every word from 0 to DEPTH-1 after reset, then parks in READY.
module ram_clr_seq
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // The reset edge itself must not touch the array.
        clr_we = !reset;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end
      end
      ST_READY: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_clr.sv
// Single-port RAM with registered read, selectable read-during-write behaviour and a
// hardware clear that zeroes every word after reset.
module ram_clr
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WRITE_FIRST = 0,
  localparam int unsigned ADDR_W     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem [DEPTH];

  ram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Only reachable as false when DEPTH is not a power of two.
  assign in_range  = 32'(address) < DEPTH;
  assign user_we   = !reset && !busy && load && in_range;
  assign mem_we    = clr_we || user_we;
  assign mem_waddr = busy ? clr_addr : address;
  assign mem_wdata = busy ? '0 : in;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // mem[] is read before this edge's write lands, which gives read-first by default.
  always_ff @(posedge clk) begin
    if (reset || busy) begin
      out <= '0;
    end else if (!in_range) begin
      out <= '0;
    end else if ((WRITE_FIRST != 0) && load) begin
      out <= in;
    end else begin
      out <= mem[address];
    end
  end

endmodule

// File: tb/tb_ram_clr.sv
// Bench for ram_clr: three instances (read-first 64x16, write-first 64x16, 48x8) share
// stimulus and are checked against a behavioural model every cycle plus directed vectors.
module tb_ram_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [5:0]  address;
  logic [15:0] din;
  logic [15:0] out0, outwf;
  logic [7:0]  out2;
  logic        busy0, busywf, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: remaining clear cycles and array images.
  logic [15:0] m0 [64];
  logic [7:0]  m2 [48];
  int          rem0, rem2;
  logic [15:0] e0, ewf;
  logic [7:0]  e2;

  typedef struct {
    logic        l;
    logic [5:0]  a;
    logic [15:0] d;
    logic [15:0] x0;
    logic [15:0] xwf;
    logic [7:0]  x2;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  ram_clr #(.WIDTH(16), .DEPTH(64), .WRITE_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .address(address), .in(din), .out(out0),
    .busy(busy0)
  );

  ram_clr #(.WIDTH(16), .DEPTH(64), .WRITE_FIRST(1)) dut_wf (
    .clk(clk), .reset(reset), .load(load), .address(address), .in(din), .out(outwf),
    .busy(busywf)
  );

  ram_clr #(.WIDTH(8), .DEPTH(48), .WRITE_FIRST(0)) dut_np (
    .clk(clk), .reset(reset), .load(load), .address(address), .in(din[7:0]), .out(out2),
    .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: apply inputs, advance the model, compare every output.
  task automatic tick(input logic r, input logic l, input logic [5:0] a, input logic [15:0] d);
    logic [15:0] old0;
    reset   = r;
    load    = l;
    address = a;
    din     = d;
    @(posedge clk);
    if (r) begin
      rem0 = 64; rem2 = 48;
      e0 = '0; ewf = '0; e2 = '0;
    end else begin
      if (rem0 > 0) begin
        m0[64 - rem0] = '0;
        rem0--;
        e0 = '0; ewf = '0;
      end else begin
        old0 = m0[a];
        e0   = old0;
        ewf  = l ? d : old0;
        if (l) m0[a] = d;
      end
      if (rem2 > 0) begin
        m2[48 - rem2] = '0;
        rem2--;
        e2 = '0;
      end else if (a < 48) begin
        e2 = m2[a];
        if (l) m2[a] = d[7:0];
      end else begin
        e2 = '0;
      end
    end
    #1;
    chk("out_rf",   32'(out0),   32'(e0));
    chk("out_wf",   32'(outwf),  32'(ewf));
    chk("out_np",   32'(out2),   32'(e2));
    chk("busy_rf",  32'(busy0),  32'(rem0 > 0));
    chk("busy_wf",  32'(busywf), 32'(rem0 > 0));
    chk("busy_np",  32'(busy2),  32'(rem2 > 0));
  endtask

  // Runs reset-free edges until both depths finish clearing; attempts writes to word 3
  // while the shorter clear is still running.
  task automatic count_busy(output int n0, output int n2);
    n0 = -1;
    n2 = -1;
    for (int i = 1; i <= 200; i++) begin
      tick(1'b0, rem2 > 0, 6'd3, 16'hAAAA);
      if (n0 < 0 && busy0 === 1'b0) n0 = i;
      if (n2 < 0 && busy2 === 1'b0) n2 = i;
      if (n0 >= 0 && n2 >= 0) break;
    end
  endtask

  initial begin
    int n0, n2;
    vecs[0]  = '{1'b1, 6'd5,  16'hBEEF, 16'h0000, 16'hBEEF, 8'h00};
    vecs[1]  = '{1'b0, 6'd5,  16'h0000, 16'hBEEF, 16'hBEEF, 8'hEF};
    vecs[2]  = '{1'b0, 6'd6,  16'h0000, 16'h0000, 16'h0000, 8'h00};
    vecs[3]  = '{1'b1, 6'd9,  16'h1111, 16'h0000, 16'h1111, 8'h00};
    vecs[4]  = '{1'b1, 6'd9,  16'h2222, 16'h1111, 16'h2222, 8'h11};
    vecs[5]  = '{1'b0, 6'd9,  16'h0000, 16'h2222, 16'h2222, 8'h22};
    vecs[6]  = '{1'b0, 6'd0,  16'h0000, 16'h0000, 16'h0000, 8'h00};
    vecs[7]  = '{1'b0, 6'd31, 16'h0000, 16'h0000, 16'h0000, 8'h00};
    vecs[8]  = '{1'b0, 6'd63, 16'h0000, 16'h0000, 16'h0000, 8'h00};
    vecs[9]  = '{1'b1, 6'd50, 16'h005A, 16'h0000, 16'h005A, 8'h00};
    vecs[10] = '{1'b0, 6'd50, 16'h0000, 16'h005A, 16'h005A, 8'h00};
    vecs[11] = '{1'b1, 6'd47, 16'h00C3, 16'h0000, 16'h00C3, 8'h00};
    vecs[12] = '{1'b0, 6'd47, 16'h0000, 16'h00C3, 16'h00C3, 8'hC3};
    vecs[13] = '{1'b0, 6'd3,  16'h0000, 16'h0000, 16'h0000, 8'h00};

    reset = 1'b1; load = 1'b0; address = '0; din = '0;
    rem0 = 0; rem2 = 0;

    // Reset for two cycles, then count the clear length with writes attempted meanwhile.
    tick(1'b1, 1'b0, 6'd0, 16'h0);
    tick(1'b1, 1'b1, 6'd7, 16'h7777);
    count_busy(n0, n2);
    chk("clear_len_64", 32'(n0), 32'd64);
    chk("clear_len_48", 32'(n2), 32'd48);

    for (int i = 0; i < 14; i++) begin
      tick(1'b0, vecs[i].l, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_rf", i), 32'(out0),  32'(vecs[i].x0));
      chk($sformatf("vec%0d_wf", i), 32'(outwf), 32'(vecs[i].xwf));
      chk($sformatf("vec%0d_np", i), 32'(out2),  32'(vecs[i].x2));
    end

    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 149) == 0), 1'($urandom), 6'($urandom_range(0, 63)),
           16'($urandom));
    end

    // Get back to READY, plant data, then restart the clear part-way through.
    tick(1'b1, 1'b0, 6'd0, 16'h0);
    count_busy(n0, n2);
    tick(1'b0, 1'b1, 6'd5, 16'h1234);
    tick(1'b0, 1'b0, 6'd5, 16'h0);
    chk("pre_restart_rd5", 32'(out0), 32'h1234);
    tick(1'b1, 1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 6'd0, 16'h0);
    tick(1'b1, 1'b0, 6'd0, 16'h0);
    count_busy(n0, n2);
    chk("restart_len_64", 32'(n0), 32'd64);
    chk("restart_len_48", 32'(n2), 32'd48);
    tick(1'b0, 1'b0, 6'd5, 16'h0);
    chk("post_restart_rd5", 32'(out0), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
